// File: rtl/inertial_integrator.sv
// Gyro offset calibration, rate integration and complementary accelerometer fusion for pitch.
// Define INERT_FUSION_EN to enable the accelerometer correction; otherwise a pure gyro integrator.
module inertial_integrator #(
   parameter logic signed [15:0] AZ_OFFSET   = 16'sh00A0,
   parameter int unsigned        CAL_LOG2    = 4,
   parameter int                 FUSION_GAIN = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               smpl_vld,
   input  logic signed [15:0] ptch_rt_raw,
   input  logic signed [15:0] AZ,
   input  logic               cal_req,
   output logic signed [15:0] ptch,
   output logic signed [15:0] ptch_rt,
   output logic               vld,
   output logic               cal_done
);

   localparam int unsigned ACC_W = 16 + CAL_LOG2;
   localparam int unsigned INT_W = 27;
   localparam int unsigned SUM_W = 28;
   localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

   typedef enum logic {CAL, RUN} state_t;

   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_sum;
   logic [CAL_LOG2-1:0]       cnt;
   logic signed [15:0]        offset;
   logic signed [15:0]        comp;
   logic                      s1_vld;
   logic signed [INT_W-1:0]   ptch_int;
   logic signed [INT_W-1:0]   int_nxt;
   logic signed [SUM_W-1:0]   int_sum;
   logic signed [SUM_W-1:0]   fus;

   assign acc_sum = acc + ACC_W'(ptch_rt_raw);
   assign ptch    = ptch_int[26:11];

`ifdef INERT_FUSION_EN
   logic signed [16:0] az_d;
   logic signed [25:0] prod;
   logic signed [15:0] ptch_acc;

   assign az_d = 17'(AZ) - 17'(AZ_OFFSET);
   assign prod = 26'(az_d) * 26'sd327;
   // Nudge the integrator toward the accelerometer angle by a fixed step each sample.
   assign fus  = (ptch_acc > ptch) ? SUM_W'(FUSION_GAIN) : -SUM_W'(FUSION_GAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptch_acc <= '0;
      else if (smpl_vld && !cal_req && state == RUN)
         ptch_acc <= {{3{prod[25]}}, prod[25:13]};
   end
`else
   logic unused_cfg;

   assign fus        = '0;
   assign unused_cfg = ^{AZ, AZ_OFFSET, 32'(FUSION_GAIN)};
`endif

   // 28-bit sum cannot overflow; clamp back into the 27-bit integrator range.
   assign int_sum = SUM_W'(ptch_int) - SUM_W'(comp) + fus;
   assign int_nxt = (int_sum[SUM_W-1] != int_sum[SUM_W-2]) ?
                    (int_sum[SUM_W-1] ? INT_MIN : INT_MAX) : int_sum[INT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CAL;
         acc      <= '0;
         cnt      <= '0;
         offset   <= '0;
         comp     <= '0;
         s1_vld   <= 1'b0;
         ptch_int <= '0;
         ptch_rt  <= '0;
         vld      <= 1'b0;
         cal_done <= 1'b0;
      end else if (cal_req) begin
         state    <= CAL;
         acc      <= '0;
         cnt      <= '0;
         s1_vld   <= 1'b0;
         ptch_int <= '0;
         vld      <= 1'b0;
         cal_done <= 1'b0;
      end else begin
         vld    <= 1'b0;
         s1_vld <= 1'b0;
         case (state)
            CAL: begin
               if (smpl_vld) begin
                  if (cnt == '1) begin
                     offset   <= 16'(acc_sum >>> CAL_LOG2);
                     acc      <= '0;
                     cnt      <= '0;
                     ptch_int <= '0;
                     state    <= RUN;
                     cal_done <= 1'b1;
                  end else begin
                     acc <= acc_sum;
                     cnt <= cnt + CAL_LOG2'(1);
                  end
               end
            end
            RUN: begin
               if (smpl_vld) begin
                  s1_vld <= 1'b1;
                  comp   <= ptch_rt_raw - offset;
               end
               if (s1_vld) begin
                  ptch_int <= int_nxt;
                  ptch_rt  <= comp;
                  vld      <= 1'b1;
               end
            end
            default: state <= CAL;
         endcase
      end
   end

endmodule

// File: tb/tb_inertial_integrator.sv
// Self-checking bench for inertial_integrator: table of per-cycle vectors plus directed corner sequences.
module tb_inertial_integrator;

   logic               clk = 1'b0;
   logic               rst;
   logic               smpl_vld;
   logic               cal_req;
   logic signed [15:0] ptch_rt_raw;
   logic signed [15:0] az;
   logic signed [15:0] ptch;
   logic signed [15:0] ptch_rt;
   logic               vld;
   logic               cal_done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        sv;
      logic [15:0] raw;
      logic [15:0] az;
      logic        creq;
      logic        ev;
      logic [15:0] ep;
      logic [15:0] ert;
      logic        ed;
   } vec_t;

   vec_t tbl[$];

   inertial_integrator dut (
      .clk        (clk),
      .rst        (rst),
      .smpl_vld   (smpl_vld),
      .ptch_rt_raw(ptch_rt_raw),
      .AZ         (az),
      .cal_req    (cal_req),
      .ptch       (ptch),
      .ptch_rt    (ptch_rt),
      .vld        (vld),
      .cal_done   (cal_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [15:0] r, input logic [15:0] a, input logic c);
      smpl_vld    = s;
      ptch_rt_raw = r;
      az          = a;
      cal_req     = c;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic sv, input logic [15:0] raw, input logic [15:0] a,
                               input logic creq, input logic ev, input logic [15:0] ep,
                               input logic [15:0] ert, input logic ed);
      vec_t v;
      v.sv = sv; v.raw = raw; v.az = a; v.creq = creq;
      v.ev = ev; v.ep = ep; v.ert = ert; v.ed = ed;
      return v;
   endfunction

   initial begin
      // Calibration: alternating 0x40/0x60 average to 0x50, with an ignored idle cycle in the middle.
      for (int i = 0; i < 16; i++) begin
         if (i == 8) tbl.push_back(mk(1'b0, 16'h7FFF, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
         tbl.push_back(mk(1'b1, (i % 2 == 1) ? 16'h0060 : 16'h0040, 16'h0, 1'b0,
                          1'b0, 16'h0, 16'h0, (i == 15)));
      end
`ifdef INERT_FUSION_EN
      tbl.push_back(mk(1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1));
      tbl.push_back(mk(1'b0, 16'h0000, 16'h00A0, 1'b0, 1'b1, 16'hFFFF, 16'h0, 1'b1));
      tbl.push_back(mk(1'b0, 16'h0000, 16'h00A0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1));
      tbl.push_back(mk(1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1));
      tbl.push_back(mk(1'b0, 16'h0000, 16'h00A0, 1'b0, 1'b1, 16'h0000, 16'h0, 1'b1));
      tbl.push_back(mk(1'b0, 16'h0000, 16'h00A0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1));
`else
      // Eight back-to-back samples, each integrating -2048 (one ptch LSB).
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1'b1, 16'h0850, 16'h0, 1'b0, (i > 0), 16'(-i),
                          (i > 0) ? 16'h0800 : 16'h0000, 1'b1));
      tbl.push_back(mk(1'b0, 16'h0000, 16'h0, 1'b0, 1'b1, 16'hFFF8, 16'h0800, 1'b1));
      tbl.push_back(mk(1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 16'hFFF8, 16'h0800, 1'b1));
`endif

      rst = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      tick();
      chk("reset.ptch", ptch, 16'h0);
      chk("reset.ptch_rt", ptch_rt, 16'h0);
      chk("reset.vld", 16'(vld), 16'h0);
      chk("reset.cal_done", 16'(cal_done), 16'h0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].sv, tbl[i].raw, tbl[i].az, tbl[i].creq);
         tick();
         chk($sformatf("vec%0d.vld", i), 16'(vld), 16'(tbl[i].ev));
         chk($sformatf("vec%0d.ptch", i), ptch, tbl[i].ep);
         chk($sformatf("vec%0d.ptch_rt", i), ptch_rt, tbl[i].ert);
         chk($sformatf("vec%0d.cal_done", i), 16'(cal_done), 16'(tbl[i].ed));
      end

      // cal_req collides with a new sample while another is in stage 1.
      drive(1'b1, 16'h0850, 16'h0, 1'b0);
      tick();
      drive(1'b1, 16'h0850, 16'h0, 1'b1);
      tick();
      chk("colreq.cal_done", 16'(cal_done), 16'h0);
      chk("colreq.vld", 16'(vld), 16'h0);
      chk("colreq.ptch", ptch, 16'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      chk("colreq.dropped_vld", 16'(vld), 16'h0);

      // Recalibrate to offset 0; the discarded sample must not count.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'h0000, 16'h0, 1'b0);
         tick();
         chk($sformatf("recal%0d.vld", i), 16'(vld), 16'h0);
         if (i == 14) chk("recal.done_early", 16'(cal_done), 16'h0);
      end
      chk("recal.done", 16'(cal_done), 16'h1);

`ifndef INERT_FUSION_EN
      // Saturation: each sample integrates +32768; clamps after 2048 updates.
      drive(1'b1, 16'h8000, 16'h0, 1'b0);
      for (int k = 1; k <= 2100; k++) begin
         tick();
         if (k == 1025) chk("sat.half", ptch, 16'h4000);
         if (k == 2048) chk("sat.before", ptch, 16'h7FF0);
         if (k == 2049) chk("sat.clamp", ptch, 16'h7FFF);
         if (k == 2100) chk("sat.stream_vld", 16'(vld), 16'h1);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      chk("sat.last_vld", 16'(vld), 16'h1);
      tick();
      chk("sat.idle_vld", 16'(vld), 16'h0);
      chk("sat.hold", ptch, 16'h7FFF);
      chk("sat.ptch_rt", ptch_rt, 16'h8000);
`endif

      // Asynchronous reset with a sample in stage 1.
      drive(1'b1, 16'h8000, 16'h0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("arst.ptch", ptch, 16'h0);
      chk("arst.ptch_rt", ptch_rt, 16'h0);
      chk("arst.vld", 16'(vld), 16'h0);
      chk("arst.cal_done", 16'(cal_done), 16'h0);
      #2 rst = 1'b0;
      tick();
      chk("arst.dropped0", 16'(vld), 16'h0);
      drive(1'b1, 16'h0100, 16'h0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      chk("arst.cal_vld", 16'(vld), 16'h0);
      chk("arst.in_cal", 16'(cal_done), 16'h0);
      chk("arst.ptch_rt_hold", ptch_rt, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inertial_integrator.md
# inertial_integrator

Converts raw inertial samples (gyro pitch rate, Z accelerometer) into the fused pitch angle `ptch`, compensated pitch rate `ptch_rt` and sample strobe `vld` that drive the PID balance controller. It sits between the inertial sensor interface and the PID controller. It calibrates the gyro offset at start-up, integrates the compensated rate, and applies a complementary accelerometer correction.

## Interface
Parameters:
- `AZ_OFFSET`, default 16'sh00A0: accelerometer Z zero-g offset.
- `CAL_LOG2`, default 4: calibration averages 2^CAL_LOG2 samples.
- `FUSION_GAIN`, default 1024: accelerometer correction added to the integrator per sample.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `smpl_vld` in 1: one-cycle pulse; the raw sample pair below is valid.
- `ptch_rt_raw` in 16 signed: raw gyro pitch rate.
- `AZ` in 16 signed: raw Z acceleration.
- `cal_req` in 1: restart calibration (level or pulse).
- `ptch` out 16 signed: fused pitch, equal to `ptch_int[26:11]`.
- `ptch_rt` out 16 signed: offset-compensated pitch rate.
- `vld` out 1: one-cycle pulse; `ptch` and `ptch_rt` have just updated.
- `cal_done` out 1: high while in RUN.

## Operation
**States**
- CAL and RUN.
- Reset enters CAL. All registers clear.
- Outputs at reset: `ptch`=0, `ptch_rt`=0, `vld`=0, `cal_done`=0.

**CAL**
- On each `smpl_vld`, sign-extend `ptch_rt_raw` and add it into a (16+CAL_LOG2)-bit accumulator, and increment the sample counter.
- On the 2^CAL_LOG2-th sample:
  - `offset` <= accumulator (including that sample) >>> CAL_LOG2, arithmetic shift.
  - Accumulator and counter clear.
  - `ptch_int` clears.
  - Go to RUN.
- No `vld` pulses are produced in CAL.

**RUN**: a two-stage pipeline that accepts `smpl_vld` every cycle.
- Stage 1, registered on `smpl_vld`:
  - `comp` = `ptch_rt_raw` − `offset`, 16-bit, wrapping.
  - `prod` = (17-bit `AZ` − `AZ_OFFSET`) × 327, signed, 26 bits.
  - `ptch_acc` = `prod[25:13]`, sign-extended to 16 bits.
- Stage 2:
  - `ptch_int` <= sat27(`ptch_int` − sext(`comp`) + `fus`).
  - `fus` = +FUSION_GAIN if `ptch_acc` > `ptch` (signed compare against the current output), otherwise −FUSION_GAIN.
  - `ptch_rt` <= `comp`.
  - `vld` <= 1.
- sat27 clamps the result to [−2^26, 2^26−1]. The integrator never wraps.

**cal_req**
- Takes priority in any state.
- Next state is CAL. Accumulator, counter, `ptch_int` and pipeline valid bits clear, and `cal_done` drops.
- `offset` keeps its old value until the new calibration completes.
- A `smpl_vld` in the same cycle as `cal_req` is discarded and not counted.
- A sample in flight in stage 1 when `cal_req` arrives is dropped, and `vld` does not pulse for it.

**Reset mid-operation**: returns immediately to the reset values.

## Timing
- `smpl_vld` in cycle N (RUN): stage 1 registers at edge N+1. `ptch`, `ptch_rt` update and `vld`=1 during cycle N+2. Latency is 2 cycles.
- Throughput: one sample per cycle. Back-to-back samples produce back-to-back `vld` pulses.
- The fusion compare uses the `ptch` visible in the update cycle. With back-to-back samples, that value lags by one sample.
- `cal_done` rises in the cycle after the edge that captures the last calibration sample. It falls in the cycle after `cal_req` is sampled.
- `vld` is never high for two consecutive cycles from a single sample.

## Configuration
- `INERT_FUSION_EN` defined: accelerometer fusion is active as described above.
- `INERT_FUSION_EN` undefined: `fus` = 0, `AZ` is ignored, and the multiplier and `ptch_acc` logic are not synthesized. The block is a pure gyro integrator with identical latency and handshake.

## Test plan
- **Calibration:** 16 samples with `ptch_rt_raw`=0x0050 (CAL_LOG2=4) -> `offset`=0x0050, `cal_done` high one cycle later, no `vld` during CAL.
- **Fusion step (fusion on):** after calibration, one sample with raw=0x0050 and `AZ`=0x00A0 -> `ptch_acc`=0, `fus`=−1024, `ptch_int`=−1024, `ptch`=0xFFFF, `ptch_rt`=0, `vld` pulses at N+2. The next such sample -> `fus`=+1024, `ptch`=0.
- **Integration (fusion off):** `offset`=0x0050, 8 back-to-back samples with raw=0x0850 -> 8 consecutive `vld` pulses, `ptch_rt`=0x0800, final `ptch_int`=−16384, `ptch`=0xFFF8.
- **Saturation (fusion off):** calibrate with raw=0, then 2100 samples with raw=0x8000 -> `ptch_int` saturates at 0x3FFFFFF, `ptch`=0x7FFF and holds; no wrap.
- **cal_req collision:** `cal_req` together with `smpl_vld` in RUN, with one sample in flight -> no further `vld`, `cal_done`=0 next cycle, `ptch`=0. The following 16 samples recalibrate.
- **Async reset:** assert `rst` mid-pipeline -> all outputs 0 immediately, state CAL.
